// File: rtl/mem_arb_pkg.sv
// Shared state and owner encodings for the imem/dmem unified memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IMEM = 1'b0,
      OWN_DMEM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way grant selection between imem and dmem requesters.
// Round-robin with a last-grant flop when MEM_ARB_RR_EN is defined, otherwise fixed dmem priority.
module mem_arb_grant
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic   clk,
   input  logic   rst_n,
   input  logic   accept,
`endif
   input  logic   imem_valid,
   input  logic   dmem_valid,
   output owner_t winner
);

`ifdef MEM_ARB_RR_EN
   owner_t last_grant;

   // On a tie, the requester that did not win the previous accept goes first.
   assign winner = (dmem_valid && (!imem_valid || (last_grant == OWN_IMEM))) ? OWN_DMEM : OWN_IMEM;

   // Remember the most recent winner at every accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= OWN_IMEM;
      end else if (accept) begin
         last_grant <= winner;
      end
   end
`else
   assign winner = dmem_valid ? OWN_DMEM : OWN_IMEM;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem), one transaction in flight.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default: dmem has fixed priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int MASK_W = DATA_W / 8
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_imem_valid,
   input  logic [ADDR_W-1:0] i_imem_addr,
   output logic              o_imem_ready,
   output logic              o_imem_rvalid,
   output logic [DATA_W-1:0] o_imem_rdata,
   input  logic              i_dmem_valid,
   input  logic [ADDR_W-1:0] i_dmem_addr,
   input  logic              i_dmem_ren,
   input  logic              i_dmem_wen,
   input  logic [DATA_W-1:0] i_dmem_wdata,
   input  logic [MASK_W-1:0] i_dmem_mask,
   output logic              o_dmem_ready,
   output logic              o_dmem_rvalid,
   output logic [DATA_W-1:0] o_dmem_rdata,
   output logic              o_mem_valid,
   input  logic              i_mem_ready,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_ren,
   output logic              o_mem_wen,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [MASK_W-1:0] o_mem_mask,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   arb_state_t state;
   owner_t     owner;
   owner_t     winner;
   logic       accept;
   logic       resp_fire;

   assign accept    = (state == ST_IDLE) && (i_imem_valid || i_dmem_valid);
   assign resp_fire = (state == ST_RESP) && i_mem_rvalid;

   mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .accept     (accept),
`endif
      .imem_valid (i_imem_valid),
      .dmem_valid (i_dmem_valid),
      .winner     (winner)
   );

   // Ready is held low while reset is asserted so no request appears accepted.
   assign o_imem_ready  = i_rst_n && accept && (winner == OWN_IMEM);
   assign o_dmem_ready  = i_rst_n && accept && (winner == OWN_DMEM);
   assign o_imem_rvalid = resp_fire && (owner == OWN_IMEM);
   assign o_dmem_rvalid = resp_fire && (owner == OWN_DMEM);
   assign o_imem_rdata  = o_imem_rvalid ? i_mem_rdata : {DATA_W{1'b0}};
   assign o_dmem_rdata  = o_dmem_rvalid ? i_mem_rdata : {DATA_W{1'b0}};

   // Transaction FSM with the captured downstream request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         owner       <= OWN_IMEM;
         o_mem_valid <= 1'b0;
         o_mem_addr  <= {ADDR_W{1'b0}};
         o_mem_ren   <= 1'b0;
         o_mem_wen   <= 1'b0;
         o_mem_wdata <= {DATA_W{1'b0}};
         o_mem_mask  <= {MASK_W{1'b0}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state       <= ST_REQ;
                  owner       <= winner;
                  o_mem_valid <= 1'b1;
                  if (winner == OWN_DMEM) begin
                     // Write wins over a simultaneous read; a request with neither becomes a masked-off read.
                     o_mem_addr  <= i_dmem_addr & ALIGN_MASK;
                     o_mem_wen   <= i_dmem_wen;
                     o_mem_ren   <= (i_dmem_ren & ~i_dmem_wen) | (~i_dmem_ren & ~i_dmem_wen);
                     o_mem_wdata <= i_dmem_wdata;
                     o_mem_mask  <= (i_dmem_ren | i_dmem_wen) ? i_dmem_mask : {MASK_W{1'b0}};
                  end else begin
                     o_mem_addr  <= i_imem_addr & ALIGN_MASK;
                     o_mem_wen   <= 1'b0;
                     o_mem_ren   <= 1'b1;
                     o_mem_wdata <= {DATA_W{1'b0}};
                     o_mem_mask  <= {MASK_W{1'b1}};
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (i_mem_ready) begin
                  state       <= ST_RESP;
                  o_mem_valid <= 1'b0;
               end else begin
                  state <= ST_REQ;
               end
            end
            ST_RESP: begin
               if (i_mem_rvalid) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RESP;
               end
            end
            default: begin
               state       <= ST_IDLE;
               o_mem_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued when the memory side answers.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_addr = 32'h0;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dmem_valid = 1'b0;
   logic [31:0] dmem_addr = 32'h0;
   logic        dmem_ren = 1'b0;
   logic        dmem_wen = 1'b0;
   logic [31:0] dmem_wdata = 32'h0;
   logic [3:0]  dmem_mask = 4'h0;
   logic        dmem_ready, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   typedef struct {
      logic        own;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   imem_pulses = 0;
   int   dmem_pulses = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_imem_valid(imem_valid), .i_imem_addr(imem_addr), .o_imem_ready(imem_ready),
      .o_imem_rvalid(imem_rvalid), .o_imem_rdata(imem_rdata),
      .i_dmem_valid(dmem_valid), .i_dmem_addr(dmem_addr), .i_dmem_ren(dmem_ren),
      .i_dmem_wen(dmem_wen), .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
      .o_dmem_ready(dmem_ready), .o_dmem_rvalid(dmem_rvalid), .o_dmem_rdata(dmem_rdata),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
      .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
   );

   // Count every response pulse seen by each requester.
   always @(posedge clk) begin
      if (imem_rvalid) imem_pulses <= imem_pulses + 1;
      if (dmem_rvalid) dmem_pulses <= dmem_pulses + 1;
   end

   // Memory answers in the current (RESP) cycle; the owner must see the data immediately.
   task automatic respond(input logic own, input logic [31:0] data);
      exp_t e;
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      exp_q.push_back('{own: own, data: data});
      #1;
      e = exp_q.pop_front();
      checks++;
      if (e.own == 1'b0) begin
         if (imem_rvalid !== 1'b1 || imem_rdata !== e.data || dmem_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL resp_imem: rvalid=%b rdata=%h dmem_rvalid=%b, want rvalid=1 rdata=%h dmem_rvalid=0",
                     imem_rvalid, imem_rdata, dmem_rvalid, e.data);
         end
      end else begin
         if (dmem_rvalid !== 1'b1 || dmem_rdata !== e.data || imem_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL resp_dmem: rvalid=%b rdata=%h imem_rvalid=%b, want rvalid=1 rdata=%h imem_rvalid=0",
                     dmem_rvalid, dmem_rdata, imem_rvalid, e.data);
         end
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
   endtask

   task automatic test_reset();
      imem_valid = 1'b1; dmem_valid = 1'b1; dmem_wen = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({imem_ready, dmem_ready, mem_valid, mem_ren, mem_wen, imem_rvalid, dmem_rvalid} !== 7'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_mask !== 4'h0 ||
          imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h mask=%h, want all zero",
                  {imem_ready, dmem_ready, mem_valid, mem_ren, mem_wen, imem_rvalid, dmem_rvalid},
                  mem_addr, mem_wdata, mem_mask);
      end
      rst_n = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0; dmem_wen = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_imem_only();
      int ip0 = imem_pulses;
      int dp0 = dmem_pulses;
      imem_valid = 1'b1; imem_addr = 32'h104; mem_ready = 1'b1;
      #1;
      checks++;
      if (imem_ready !== 1'b1 || dmem_ready !== 1'b0) begin
         errors++;
         $display("FAIL imem_ready: imem=%b dmem=%b, want 1 0", imem_ready, dmem_ready);
      end
      @(negedge clk);
      imem_valid = 1'b0;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h104 || mem_mask !== 4'hF || mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
         errors++;
         $display("FAIL imem_req: valid=%b addr=%h mask=%h ren=%b wen=%b, want 1 00000104 f 1 0",
                  mem_valid, mem_addr, mem_mask, mem_ren, mem_wen);
      end
      @(negedge clk);
      respond(1'b0, 32'h0000_0013);
      checks++;
      if (imem_pulses - ip0 != 1 || dmem_pulses - dp0 != 0) begin
         errors++;
         $display("FAIL imem_pulses: imem=%0d dmem=%0d, want 1 0", imem_pulses - ip0, dmem_pulses - dp0);
      end
   endtask

   task automatic test_fixed_priority();
      int ip0 = imem_pulses;
      int dp0 = dmem_pulses;
      imem_valid = 1'b1; imem_addr = 32'h0;
      dmem_valid = 1'b1; dmem_addr = 32'h2003; dmem_wen = 1'b1; dmem_ren = 1'b0;
      dmem_wdata = 32'hAB00_0000; dmem_mask = 4'b1000;
      #1;
      checks++;
      if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin
         errors++;
         $display("FAIL prio_first: dmem=%b imem=%b, want 1 0", dmem_ready, imem_ready);
      end
      @(negedge clk);
      dmem_valid = 1'b0; dmem_wen = 1'b0;
      checks++;
      if (mem_addr !== 32'h2000 || mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_mask !== 4'b1000 ||
          mem_wdata !== 32'hAB00_0000 || imem_ready !== 1'b0) begin
         errors++;
         $display("FAIL prio_store: addr=%h wen=%b ren=%b mask=%b wdata=%h imem_ready=%b, want 00002000 1 0 1000 ab000000 0",
                  mem_addr, mem_wen, mem_ren, mem_mask, mem_wdata, imem_ready);
      end
      @(negedge clk);
      respond(1'b1, 32'h0);
      checks++;
      if (imem_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio_second: imem_ready=%b, want 1", imem_ready);
      end
      @(negedge clk);
      imem_valid = 1'b0;
      checks++;
      if (mem_addr !== 32'h0 || mem_mask !== 4'hF || mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
         errors++;
         $display("FAIL prio_fetch: addr=%h mask=%h ren=%b wen=%b, want 0 f 1 0", mem_addr, mem_mask, mem_ren, mem_wen);
      end
      @(negedge clk);
      respond(1'b0, 32'h0000_0093);
      checks++;
      if (imem_pulses - ip0 != 1 || dmem_pulses - dp0 != 1) begin
         errors++;
         $display("FAIL prio_pulses: imem=%0d dmem=%0d, want 1 1", imem_pulses - ip0, dmem_pulses - dp0);
      end
   endtask

   task automatic test_round_robin();
      logic exp_d;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      imem_valid = 1'b1; imem_addr = 32'h300;
      dmem_valid = 1'b1; dmem_addr = 32'h400; dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_mask = 4'hF;
      for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
         exp_d = (g % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         #1;
         checks++;
         if (dmem_ready !== exp_d || imem_ready !== ~exp_d) begin
            errors++;
            $display("FAIL grant_%0d: dmem_ready=%b imem_ready=%b, want dmem_ready=%b", g, dmem_ready, imem_ready, exp_d);
         end
         @(negedge clk);
         checks++;
         if (mem_addr !== (exp_d ? 32'h400 : 32'h300)) begin
            errors++;
            $display("FAIL grant_addr_%0d: addr=%h, want %h", g, mem_addr, exp_d ? 32'h400 : 32'h300);
         end
         @(negedge clk);
         respond(exp_d, 32'hA000 + 32'(g));
      end
      imem_valid = 1'b0; dmem_valid = 1'b0; dmem_ren = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      mem_ready = 1'b0;
      dmem_valid = 1'b1; dmem_addr = 32'h55; dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_mask = 4'hF;
      #1;
      checks++;
      if (dmem_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_accept: dmem_ready=%b, want 1", dmem_ready);
      end
      @(negedge clk);
      dmem_valid = 1'b0; dmem_ren = 1'b0; imem_valid = 1'b1; imem_addr = 32'h500;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (mem_valid !== 1'b1 || mem_addr !== 32'h54 || mem_ren !== 1'b1 || mem_wen !== 1'b0 ||
             mem_mask !== 4'hF || imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%b addr=%h ren=%b wen=%b mask=%h ready=%b%b, want 1 00000054 1 0 f 00",
                     c, mem_valid, mem_addr, mem_ren, mem_wen, mem_mask, imem_ready, dmem_ready);
         end
         if (c == 5) mem_ready = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: mem_valid=%b, want 0", mem_valid);
      end
      respond(1'b1, 32'hCAFE_0055);
      checks++;
      if (imem_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_next: imem_ready=%b, want 1", imem_ready);
      end
      @(negedge clk);
      imem_valid = 1'b0;
      @(negedge clk);
      respond(1'b0, 32'h0000_0500);
   endtask

   task automatic test_spurious();
      int ip0 = imem_pulses;
      int dp0 = dmem_pulses;
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
      #1;
      checks++;
      if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL spur_idle: rvalid=%b%b, want 00", imem_rvalid, dmem_rvalid);
      end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_ready = 1'b0; imem_valid = 1'b1; imem_addr = 32'h600;
      #1;
      checks++;
      if (imem_ready !== 1'b1) begin
         errors++;
         $display("FAIL spur_still_idle: imem_ready=%b, want 1", imem_ready);
      end
      @(negedge clk);
      imem_valid = 1'b0; mem_rvalid = 1'b1;
      #1;
      checks++;
      if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL spur_req: rvalid=%b%b, want 00", imem_rvalid, dmem_rvalid);
      end
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL spur_still_req: mem_valid=%b, want 1", mem_valid);
      end
      mem_rvalid = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      respond(1'b0, 32'h0000_0600);
      checks++;
      if (imem_pulses - ip0 != 1 || dmem_pulses - dp0 != 0) begin
         errors++;
         $display("FAIL spur_pulses: imem=%0d dmem=%0d, want 1 0", imem_pulses - ip0, dmem_pulses - dp0);
      end
   endtask

   task automatic test_dmem_corner();
      dmem_valid = 1'b1; dmem_addr = 32'h707; dmem_ren = 1'b1; dmem_wen = 1'b1;
      dmem_mask = 4'b0011; dmem_wdata = 32'h0000_1234;
      @(negedge clk);
      dmem_valid = 1'b0;
      checks++;
      if (mem_ren !== 1'b0 || mem_wen !== 1'b1 || mem_mask !== 4'b0011 || mem_addr !== 32'h704 || mem_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL rw_both: ren=%b wen=%b mask=%b addr=%h wdata=%h, want 0 1 0011 00000704 00001234",
                  mem_ren, mem_wen, mem_mask, mem_addr, mem_wdata);
      end
      @(negedge clk);
      respond(1'b1, 32'h0);
      dmem_valid = 1'b1; dmem_addr = 32'h800; dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_mask = 4'hF;
      @(negedge clk);
      dmem_valid = 1'b0;
      checks++;
      if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_mask !== 4'h0 || mem_addr !== 32'h800) begin
         errors++;
         $display("FAIL noop_req: ren=%b wen=%b mask=%h addr=%h, want 1 0 0 00000800", mem_ren, mem_wen, mem_mask, mem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dmem_rvalid !== 1'b0 || dmem_ready !== 1'b0) begin
         errors++;
         $display("FAIL noop_wait: rvalid=%b ready=%b, want 0 0", dmem_rvalid, dmem_ready);
      end
      respond(1'b1, 32'h0000_0800);
   endtask

   task automatic test_reset_mid();
      int ip0 = imem_pulses;
      int dp0 = dmem_pulses;
      mem_ready = 1'b1; imem_valid = 1'b1; imem_addr = 32'h900;
      @(negedge clk);
      imem_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0900;
      #1;
      checks++;
      if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_mask !== 4'h0 || mem_ren !== 1'b0 ||
          imem_rvalid !== 1'b0 || imem_rdata !== 32'h0 || imem_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: valid=%b addr=%h mask=%h ren=%b rvalid=%b rdata=%h ready=%b, want all zero",
                  mem_valid, mem_addr, mem_mask, mem_ren, imem_rvalid, imem_rdata, imem_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_resp: rvalid=%b%b mem_valid=%b, want 00 0", imem_rvalid, dmem_rvalid, mem_valid);
      end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      dmem_valid = 1'b1; dmem_addr = 32'hA08; dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_mask = 4'hF;
      #1;
      checks++;
      if (dmem_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_next_accept: dmem_ready=%b, want 1", dmem_ready);
      end
      @(negedge clk);
      dmem_valid = 1'b0; dmem_ren = 1'b0;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'hA08 || mem_ren !== 1'b1) begin
         errors++;
         $display("FAIL rst_next_req: valid=%b addr=%h ren=%b, want 1 00000a08 1", mem_valid, mem_addr, mem_ren);
      end
      @(negedge clk);
      respond(1'b1, 32'h5A5A_5A5A);
      checks++;
      if (imem_pulses - ip0 != 0 || dmem_pulses - dp0 != 1) begin
         errors++;
         $display("FAIL rst_pulses: imem=%0d dmem=%0d, want 0 1", imem_pulses - ip0, dmem_pulses - dp0);
      end
   endtask

   initial begin
      test_reset();
      test_imem_only();
      test_fixed_priority();
      test_round_robin();
      test_backpressure();
      test_spurious();
      test_dmem_corner();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
